// File: rtl/maze_video_pkg.sv
// ---------------------------------------------------------------------------
// maze_video_pkg
// Shared types and constants for the maze video pipeline: the binarizer
// FSM state encoding, pixel width and the two saturated pixel levels, the
// video-sync bundle, and a small 3-input majority helper.
// Also used by the downstream maze path-finder stage.
// ---------------------------------------------------------------------------
package maze_video_pkg;

  localparam int PIX_W = 8;
  localparam logic [PIX_W-1:0] PIX_WHITE = 8'hFF;
  localparam logic [PIX_W-1:0] PIX_BLACK = 8'h00;

  // Binarizer defaults
  localparam logic [PIX_W-1:0] DEFAULT_THR_C  = 8'd150;
  localparam logic [PIX_W-1:0] THR_MIN_C      = 8'd40;
  localparam logic [PIX_W-1:0] THR_MAX_C      = 8'd220;
  localparam logic [PIX_W-1:0] MIN_CONTRAST_C = 8'd32;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    WAIT_FRAME,
    IN_FRAME,
    UPDATE
  } bin_state_e;

  typedef struct packed {
    logic frame_valid;
    logic line_valid;
    logic data_valid;
  } video_sync_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/maze_binarizer_frame_minmax_stats.sv
// ---------------------------------------------------------------------------
// frame_minmax_stats
// Per-frame running min/max of accepted pixels. From them it derives the
// threshold for the next frame and whether the frame had enough contrast.
//
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   clear           : restart statistics (min=0xFF, max=0x00, nothing seen)
//   sample_en       : fold pix into the running min/max this cycle
//   pix             : pixel value
//   threshold_next  : clamp((min+max)>>1, THR_MIN, THR_MAX)
//   contrast_ok     : at least one pixel seen and (max-min) >= MIN_CONTRAST
// ---------------------------------------------------------------------------
module frame_minmax_stats
  import maze_video_pkg::*;
#(
  parameter logic [7:0] THR_MIN      = THR_MIN_C,
  parameter logic [7:0] THR_MAX      = THR_MAX_C,
  parameter logic [7:0] MIN_CONTRAST = MIN_CONTRAST_C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       sample_en,
  input  logic [7:0] pix,
  output logic [7:0] threshold_next,
  output logic       contrast_ok
);

  logic [7:0] min_q, min_d;
  logic [7:0] max_q, max_d;
  logic       seen_q, seen_d;
  logic [7:0] mid;
  logic [8:0] span;

  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    seen_d = seen_q;
    if (clear) begin
      min_d  = PIX_WHITE;
      max_d  = PIX_BLACK;
      seen_d = 1'b0;
    end else if (sample_en) begin
      if (pix < min_q) min_d = pix;
      if (pix > max_q) max_d = pix;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      min_q  <= PIX_WHITE;
      max_q  <= PIX_BLACK;
      seen_q <= 1'b0;
    end else begin
      min_q  <= min_d;
      max_q  <= max_d;
      seen_q <= seen_d;
    end
  end

  // The sum needs 9 bits (e.g. 200+255); the midpoint is then narrowed back.
  // The span is only meaningful once a pixel has been seen (max >= min).
  always_comb begin
    mid  = 8'(({1'b0, min_q} + {1'b0, max_q}) >> 1);
    span = {1'b0, max_q} - {1'b0, min_q};
    threshold_next = mid;
    if (mid < THR_MIN)      threshold_next = THR_MIN;
    else if (mid > THR_MAX) threshold_next = THR_MAX;
    contrast_ok = seen_q && (span >= {1'b0, MIN_CONTRAST});
  end

endmodule

// File: rtl/maze_binarizer.sv
// ---------------------------------------------------------------------------
// maze_binarizer
// Converts a raw 8-bit grey camera stream into a 0x00/0xFF stream using an
// adaptive threshold. The min/max midpoint of one frame becomes the
// threshold of the next one. Sync signals are delayed to match the data.
//
// Optional feature macro: MAZE_BINARIZER_MAJORITY_EN
//   defined   : causal 3-tap horizontal majority filter after binarization,
//               latency 2 clocks
//   undefined : binarized pixel is output directly, latency 1 clock
//
// Ports:
//   clk, reset                   : clock, synchronous active-low reset
//   video_frame/line/data_valid  : input sync signals
//   video_data_in                : raw grey pixel
//   video_*_valid_out            : sync delayed by the pipeline latency
//   video_data_out               : 0x00 / 0xFF, 0x00 whenever not data-valid
//   threshold                    : threshold currently applied
//   stats_valid                  : one-cycle pulse when frame stats evaluate
//   low_contrast                 : last evaluated frame lacked contrast
// ---------------------------------------------------------------------------
module maze_binarizer
  import maze_video_pkg::*;
#(
  parameter logic [7:0] DEFAULT_THR  = DEFAULT_THR_C,
  parameter logic [7:0] THR_MIN      = THR_MIN_C,
  parameter logic [7:0] THR_MAX      = THR_MAX_C,
  parameter logic [7:0] MIN_CONTRAST = MIN_CONTRAST_C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_frame_valid,
  input  logic       video_line_valid,
  input  logic       video_data_valid,
  input  logic [7:0] video_data_in,
  output logic       video_frame_valid_out,
  output logic       video_line_valid_out,
  output logic       video_data_valid_out,
  output logic [7:0] video_data_out,
  output logic [7:0] threshold,
  output logic       stats_valid,
  output logic       low_contrast
);

  bin_state_e  state_q, state_d;
  logic        frame_valid_q, frame_valid_d;
  logic [7:0]  threshold_q, threshold_d;
  logic        low_contrast_q, low_contrast_d;
  video_sync_t s1_q, s1_d;
  logic        bin1_q, bin1_d;

  logic        frame_rise, frame_fall;
  logic        pass_en, sample_en, stats_clear;
  logic [7:0]  threshold_next;
  logic        contrast_ok;

  frame_minmax_stats #(
    .THR_MIN      (THR_MIN),
    .THR_MAX      (THR_MAX),
    .MIN_CONTRAST (MIN_CONTRAST)
  ) u_stats (
    .clk            (clk),
    .reset          (reset),
    .clear          (stats_clear),
    .sample_en      (sample_en),
    .pix            (video_data_in),
    .threshold_next (threshold_next),
    .contrast_ok    (contrast_ok)
  );

  assign frame_valid_d = video_frame_valid;
  assign frame_rise    = video_frame_valid & ~frame_valid_q;
  assign frame_fall    = ~video_frame_valid & frame_valid_q;

  // Frame FSM. The rise cycle itself already passes through so the first
  // pixels of the frame are not lost. A rise seen during UPDATE is ignored,
  // and because frame_valid_q is then already high that frame is dropped.
  always_comb begin
    state_d     = state_q;
    pass_en     = 1'b0;
    stats_clear = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (!video_frame_valid) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (frame_rise) begin
          state_d = IN_FRAME;
          pass_en = 1'b1;
        end
      end
      IN_FRAME: begin
        pass_en = 1'b1;
        if (frame_fall) state_d = UPDATE;
      end
      UPDATE: begin
        stats_clear = 1'b1;
        state_d     = WAIT_FRAME;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign sample_en = pass_en & video_data_valid;

  always_comb begin
    threshold_d    = threshold_q;
    low_contrast_d = low_contrast_q;
    if (state_q == UPDATE) begin
      if (contrast_ok) begin
        threshold_d    = threshold_next;
        low_contrast_d = 1'b0;
      end else begin
        low_contrast_d = 1'b1;
      end
    end
  end

  // First pipeline stage: gated sync plus the binarized bit.
  always_comb begin
    s1_d   = '0;
    bin1_d = 1'b0;
    if (pass_en) begin
      s1_d.frame_valid = video_frame_valid;
      s1_d.line_valid  = video_line_valid;
      s1_d.data_valid  = video_data_valid;
      bin1_d           = video_data_valid && (video_data_in > threshold_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= WAIT_IDLE;
      frame_valid_q  <= 1'b0;
      threshold_q    <= DEFAULT_THR;
      low_contrast_q <= 1'b0;
      s1_q           <= '0;
      bin1_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_valid_q  <= frame_valid_d;
      threshold_q    <= threshold_d;
      low_contrast_q <= low_contrast_d;
      s1_q           <= s1_d;
      bin1_q         <= bin1_d;
    end
  end

  assign threshold    = threshold_q;
  assign low_contrast = low_contrast_q;
  assign stats_valid  = (state_q == UPDATE);

`ifdef MAZE_BINARIZER_MAJORITY_EN
  video_sync_t s2_q, s2_d;
  logic        out2_q, out2_d;
  logic        hist1_q, hist1_d;
  logic        hist2_q, hist2_d;
  logic [1:0]  cnt_q, cnt_d;

  // Majority over the current and two previous bits of the same line.
  // cnt_q counts pixels already seen in the line (saturating at 2); while
  // fewer than two predecessors exist, the current bit stands in for them,
  // which makes the output equal the current bit.
  always_comb begin
    s2_d    = s1_q;
    out2_d  = 1'b0;
    hist1_d = hist1_q;
    hist2_d = hist2_q;
    cnt_d   = cnt_q;
    if (!s1_q.line_valid) begin
      cnt_d = 2'd0;
    end else if (s1_q.data_valid) begin
      out2_d  = (cnt_q == 2'd2) ? maj3(bin1_q, hist1_q, hist2_q) : bin1_q;
      hist2_d = hist1_q;
      hist1_d = bin1_q;
      if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_q    <= '0;
      out2_q  <= 1'b0;
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      s2_q    <= s2_d;
      out2_q  <= out2_d;
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign video_frame_valid_out = s2_q.frame_valid;
  assign video_line_valid_out  = s2_q.line_valid;
  assign video_data_valid_out  = s2_q.data_valid;
  assign video_data_out        = (s2_q.data_valid && out2_q) ? PIX_WHITE : PIX_BLACK;
`else
  assign video_frame_valid_out = s1_q.frame_valid;
  assign video_line_valid_out  = s1_q.line_valid;
  assign video_data_valid_out  = s1_q.data_valid;
  assign video_data_out        = (s1_q.data_valid && bin1_q) ? PIX_WHITE : PIX_BLACK;
`endif

endmodule

// File: tb/tb_maze_binarizer.sv
// ---------------------------------------------------------------------------
// tb_maze_binarizer
// Directed self-checking bench for maze_binarizer. Works for both builds:
// MAZE_BINARIZER_MAJORITY_EN selects the latency and the expected pixels.
// ---------------------------------------------------------------------------
module tb_maze_binarizer;

`ifdef MAZE_BINARIZER_MAJORITY_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  typedef struct packed {
    logic       fv;
    logic       lv;
    logic       dv;
    logic [7:0] pix;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       video_frame_valid = 1'b0;
  logic       video_line_valid = 1'b0;
  logic       video_data_valid = 1'b0;
  logic [7:0] video_data_in = 8'd0;
  logic       video_frame_valid_out;
  logic       video_line_valid_out;
  logic       video_data_valid_out;
  logic [7:0] video_data_out;
  logic [7:0] threshold;
  logic       stats_valid;
  logic       low_contrast;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] frame_pix[$];
  logic [7:0] out_pix[$];
  logic [7:0] exp_pix[$];

  maze_binarizer dut (
    .clk                   (clk),
    .reset                 (reset),
    .video_frame_valid     (video_frame_valid),
    .video_line_valid      (video_line_valid),
    .video_data_valid      (video_data_valid),
    .video_data_in         (video_data_in),
    .video_frame_valid_out (video_frame_valid_out),
    .video_line_valid_out  (video_line_valid_out),
    .video_data_valid_out  (video_data_valid_out),
    .video_data_out        (video_data_out),
    .threshold             (threshold),
    .stats_valid           (stats_valid),
    .low_contrast          (low_contrast)
  );

  always #5 clk = ~clk;

  // Apply one cycle of input, then sample just after the clock edge and
  // record any data-valid output pixel.
  task automatic drive(input logic fv, input logic lv, input logic dv, input logic [7:0] pix);
    video_frame_valid = fv;
    video_line_valid  = lv;
    video_data_valid  = dv;
    video_data_in     = pix;
    @(posedge clk);
    #1;
    if (video_data_valid_out) out_pix.push_back(video_data_out);
  endtask

  // One frame with a single line holding frame_pix; returns right after the
  // cycle in which frame_valid falls.
  task automatic send_frame();
    out_pix.delete();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    foreach (frame_pix[i]) drive(1'b1, 1'b1, 1'b1, frame_pix[i]);
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 1'b1, 8'd200);
      vectors++;
      if ({video_frame_valid_out, video_line_valid_out, video_data_valid_out, video_data_out} !== 11'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_outputs cycle %0d got %b/%h want 000/00", c,
                 {video_frame_valid_out, video_line_valid_out, video_data_valid_out}, video_data_out);
      end
    end
    vectors++;
    if (threshold !== 8'd150) begin
      miscompares++;
      $display("[TB] FAIL reset_threshold got %0d want 150", threshold);
    end
    vectors++;
    if ({stats_valid, low_contrast} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b want 00", {stats_valid, low_contrast});
    end
    // Release in the middle of a frame: nothing may come out of it.
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b1, 8'd200);
      vectors++;
      if ({video_frame_valid_out, video_line_valid_out, video_data_valid_out} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL reset_partial_frame cycle %0d got %b want 000", c,
                 {video_frame_valid_out, video_line_valid_out, video_data_valid_out});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (threshold !== 8'd150) begin
      miscompares++;
      $display("[TB] FAIL reset_threshold_after got %0d want 150", threshold);
    end
  endtask

  task automatic test_threshold_update();
    frame_pix = '{8'd20, 8'd200, 8'd100, 8'd57};
    exp_pix   = '{8'h00, 8'hFF, 8'h00, 8'h00};
    send_frame();
    vectors++;
    if (stats_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL thr_stats_pulse got %b want 1", stats_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (stats_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL thr_stats_width got %b want 0", stats_valid);
    end
    vectors++;
    if (threshold !== 8'd110 || low_contrast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL thr_update got %0d/lc=%b want 110/lc=0", threshold, low_contrast);
    end
    vectors++;
    if (out_pix.size() != exp_pix.size()) begin
      miscompares++;
      $display("[TB] FAIL thr_pix_count got %0d want %0d", out_pix.size(), exp_pix.size());
    end else begin
      foreach (exp_pix[i]) begin
        vectors++;
        if (out_pix[i] !== exp_pix[i]) begin
          miscompares++;
          $display("[TB] FAIL thr_pix[%0d] got %h want %h", i, out_pix[i], exp_pix[i]);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_low_contrast();
    // Threshold 110: equal gives black, one above gives white.
    frame_pix = '{8'd100, 8'd110, 8'd111, 8'd120};
    exp_pix   = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    send_frame();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (threshold !== 8'd110 || low_contrast !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL lowc_update got %0d/lc=%b want 110/lc=1", threshold, low_contrast);
    end
    vectors++;
    if (out_pix.size() != exp_pix.size()) begin
      miscompares++;
      $display("[TB] FAIL lowc_pix_count got %0d want %0d", out_pix.size(), exp_pix.size());
    end else begin
      foreach (exp_pix[i]) begin
        vectors++;
        if (out_pix[i] !== exp_pix[i]) begin
          miscompares++;
          $display("[TB] FAIL lowc_pix[%0d] got %h want %h", i, out_pix[i], exp_pix[i]);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_clamp();
    // Midpoint 20 clamps up to 40.
    frame_pix = '{8'd0, 8'd40, 8'd10};
    send_frame();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (threshold !== 8'd40 || low_contrast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clamp_low got %0d/lc=%b want 40/lc=0", threshold, low_contrast);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    // Threshold 40 makes everything white; midpoint 227 (9-bit sum) clamps to 220.
    frame_pix = '{8'd200, 8'd255, 8'd230};
    exp_pix   = '{8'hFF, 8'hFF, 8'hFF};
    send_frame();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (threshold !== 8'd220 || low_contrast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clamp_high got %0d/lc=%b want 220/lc=0", threshold, low_contrast);
    end
    vectors++;
    if (out_pix.size() != exp_pix.size()) begin
      miscompares++;
      $display("[TB] FAIL clamp_pix_count got %0d want %0d", out_pix.size(), exp_pix.size());
    end else begin
      foreach (exp_pix[i]) begin
        vectors++;
        if (out_pix[i] !== exp_pix[i]) begin
          miscompares++;
          $display("[TB] FAIL clamp_pix[%0d] got %h want %h", i, out_pix[i], exp_pix[i]);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    // Threshold 220 at the boundary; this frame's midpoint is 220 again.
    frame_pix = '{8'd220, 8'd221, 8'd200, 8'd240};
    exp_pix   = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    send_frame();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (out_pix.size() != exp_pix.size()) begin
      miscompares++;
      $display("[TB] FAIL edge_pix_count got %0d want %0d", out_pix.size(), exp_pix.size());
    end else begin
      foreach (exp_pix[i]) begin
        vectors++;
        if (out_pix[i] !== exp_pix[i]) begin
          miscompares++;
          $display("[TB] FAIL edge_pix[%0d] got %h want %h", i, out_pix[i], exp_pix[i]);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    // A frame with no pixels at all counts as low contrast.
    frame_pix.delete();
    send_frame();
    vectors++;
    if (stats_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL empty_stats_pulse got %b want 1", stats_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (threshold !== 8'd220 || low_contrast !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL empty_frame got %0d/lc=%b want 220/lc=1", threshold, low_contrast);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_gaps();
    stim_t      stim[$];
    stim_t      s;
    stim_t      hist[$];
    stim_t      e;
    logic [31:0] mask = 32'b1011_0011_1000_1101_1110_0101_0011_0111;
    logic [7:0] thr_m = 8'd220;
    logic       b;
    logic       y;
`ifdef MAZE_BINARIZER_MAJORITY_EN
    int   bc = 0;
    logic bh1 = 1'b0;
    logic bh2 = 1'b0;
`endif
    s = '{fv: 1'b0, lv: 1'b0, dv: 1'b0, pix: 8'd0};
    stim.push_back(s);
    stim.push_back(s);
    s.fv = 1'b1;
    stim.push_back(s);
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 16; i++) begin
        s.lv  = 1'b1;
        s.dv  = mask[ln*16+i];
        s.pix = 8'(180 + 29 * (ln * 16 + i));
        stim.push_back(s);
      end
      s = '{fv: 1'b1, lv: 1'b0, dv: 1'b0, pix: 8'd0};
      stim.push_back(s);
    end
    s = '{fv: 1'b0, lv: 1'b0, dv: 1'b0, pix: 8'd0};
    for (int i = 0; i < 4; i++) stim.push_back(s);

    foreach (stim[k]) begin
      drive(stim[k].fv, stim[k].lv, stim[k].dv, stim[k].pix);
      b = stim[k].pix > thr_m;
      y = 1'b0;
`ifdef MAZE_BINARIZER_MAJORITY_EN
      if (!stim[k].lv) begin
        bc = 0;
      end else if (stim[k].dv) begin
        y   = (bc >= 2) ? ((b & bh1) | (b & bh2) | (bh1 & bh2)) : b;
        bh2 = bh1;
        bh1 = b;
        bc++;
      end
`else
      if (stim[k].dv) y = b;
`endif
      e = '{fv: stim[k].fv, lv: stim[k].lv, dv: stim[k].dv, pix: (y ? 8'hFF : 8'h00)};
      hist.push_back(e);
      if (hist.size() >= L) begin
        e = hist[hist.size() - L];
        vectors++;
        if ({video_frame_valid_out, video_line_valid_out, video_data_valid_out} !== {e.fv, e.lv, e.dv}) begin
          miscompares++;
          $display("[TB] FAIL gap_valids cycle %0d got %b want %b", k,
                   {video_frame_valid_out, video_line_valid_out, video_data_valid_out}, {e.fv, e.lv, e.dv});
        end
        vectors++;
        if (video_data_out !== e.pix) begin
          miscompares++;
          $display("[TB] FAIL gap_data cycle %0d got %h want %h", k, video_data_out, e.pix);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b1, 1'b1, 1'b1, 8'd30);
    drive(1'b1, 1'b1, 1'b1, 8'd250);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'd250);
    vectors++;
    if ({video_frame_valid_out, video_line_valid_out, video_data_valid_out, video_data_out} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL midrst_quiet got %b/%h want 000/00",
               {video_frame_valid_out, video_line_valid_out, video_data_valid_out}, video_data_out);
    end
    vectors++;
    if (threshold !== 8'd150) begin
      miscompares++;
      $display("[TB] FAIL midrst_threshold got %0d want 150", threshold);
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b1, 8'd250);
      vectors++;
      if ({video_frame_valid_out, video_line_valid_out, video_data_valid_out} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL midrst_partial cycle %0d got %b want 000", c,
                 {video_frame_valid_out, video_line_valid_out, video_data_valid_out});
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (stats_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midrst_no_stats got %b want 0", stats_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if ({stats_valid, low_contrast} !== 2'b00 || threshold !== 8'd150) begin
      miscompares++;
      $display("[TB] FAIL midrst_after got sv=%b lc=%b thr=%0d want sv=0 lc=0 thr=150",
               stats_valid, low_contrast, threshold);
    end
  endtask

  task automatic test_majority();
    frame_pix = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0};
`ifdef MAZE_BINARIZER_MAJORITY_EN
    exp_pix = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
`else
    exp_pix = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
`endif
    send_frame();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (out_pix.size() != exp_pix.size()) begin
      miscompares++;
      $display("[TB] FAIL maj_pix_count got %0d want %0d", out_pix.size(), exp_pix.size());
    end else begin
      foreach (exp_pix[i]) begin
        vectors++;
        if (out_pix[i] !== exp_pix[i]) begin
          miscompares++;
          $display("[TB] FAIL maj_pix[%0d] got %h want %h", i, out_pix[i], exp_pix[i]);
        end
      end
    end
    vectors++;
    if (threshold !== 8'd127) begin
      miscompares++;
      $display("[TB] FAIL maj_threshold got %0d want 127", threshold);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_back_to_back();
    frame_pix = '{8'd10, 8'd90};
    send_frame();
    vectors++;
    if (stats_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_stats_pulse got %b want 1", stats_valid);
    end
    // frame_valid rises during UPDATE: this frame must be dropped whole.
    out_pix.delete();
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (threshold !== 8'd50) begin
      miscompares++;
      $display("[TB] FAIL b2b_threshold got %0d want 50", threshold);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b1, 8'd200);
      vectors++;
      if ({video_frame_valid_out, video_line_valid_out, video_data_valid_out} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL b2b_dropped cycle %0d got %b want 000", c,
                 {video_frame_valid_out, video_line_valid_out, video_data_valid_out});
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (stats_valid !== 1'b0 || threshold !== 8'd50 || out_pix.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_no_update got sv=%b thr=%0d npix=%0d want sv=0 thr=50 npix=0",
               stats_valid, threshold, out_pix.size());
    end
    // The next properly spaced frame is accepted again.
    frame_pix = '{8'd51, 8'd50};
    exp_pix   = '{8'hFF, 8'h00};
    send_frame();
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    vectors++;
    if (out_pix.size() != exp_pix.size()) begin
      miscompares++;
      $display("[TB] FAIL b2b_pix_count got %0d want %0d", out_pix.size(), exp_pix.size());
    end else begin
      foreach (exp_pix[i]) begin
        vectors++;
        if (out_pix[i] !== exp_pix[i]) begin
          miscompares++;
          $display("[TB] FAIL b2b_pix[%0d] got %h want %h", i, out_pix[i], exp_pix[i]);
        end
      end
    end
    vectors++;
    if (low_contrast !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_low_contrast got %b want 1", low_contrast);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    test_reset();
    test_threshold_update();
    test_low_contrast();
    test_clamp();
    test_gaps();
    test_reset_mid_frame();
    test_majority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maze_binarizer.md
Name: maze_binarizer

Overview:
Upstream neighbour of the maze path-finder stage. Converts the raw 8-bit camera stream into a clean two-level stream of 0x00/0xFF pixels. It uses a per-frame adaptive threshold: the min/max midpoint of frame N is applied to frame N+1. It passes the video sync signals through with matched latency, so the downstream stage's fixed threshold of 150 always sees a saturated image.

Parameters:
DEFAULT_THR, 150, threshold used after reset and until the first valid frame update
THR_MIN, 40, lower clamp of computed threshold
THR_MAX, 220, upper clamp of computed threshold
MIN_CONTRAST, 32, minimum (max-min) for a frame to update the threshold

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
video_frame_valid  in  1  high for the whole frame
video_line_valid  in  1  high for the whole line
video_data_valid  in  1  pixel strobe
video_data_in  in  8  raw grey pixel
video_frame_valid_out  out  1  delayed frame_valid
video_line_valid_out  out  1  delayed line_valid
video_data_valid_out  out  1  delayed data_valid
video_data_out  out  8  0x00 or 0xFF
threshold  out  8  threshold currently applied
stats_valid  out  1  one-cycle pulse when the frame statistics are evaluated
low_contrast  out  1  last evaluated frame had (max-min) < MIN_CONTRAST

Behaviour:
- Reset (reset==0 at posedge clk) clears:
  - all *_out valids, video_data_out, stats_valid, low_contrast, and all pipeline stages to 0.
  - threshold to DEFAULT_THR; running min to 0xFF, running max to 0x00; FSM to WAIT_IDLE.
- FSM states:
  - WAIT_IDLE: output valids forced 0. Go to WAIT_FRAME when video_frame_valid==0. This ensures no partial frame follows reset.
  - WAIT_FRAME: valids forced 0. On a video_frame_valid 0->1 edge, go to IN_FRAME; that first frame's pixels pass through.
  - IN_FRAME: pass-through active. On every video_data_valid, min<=min(min,pix) and max<=max(max,pix). On a video_frame_valid 1->0 edge, go to UPDATE.
  - UPDATE (exactly 1 cycle): pulse stats_valid.
    - If at least one pixel was seen and (max-min)>=MIN_CONTRAST: threshold <= clamp((min+max)>>1, THR_MIN, THR_MAX), with a 9-bit sum; low_contrast<=0.
    - Otherwise: threshold is unchanged; low_contrast<=1. This includes a frame with zero pixels.
    - Then min<=0xFF, max<=0x00; go to WAIT_FRAME.
- Edge detection uses registered copies of video_frame_valid.
- Frames must be separated by at least 2 idle cycles. A frame_valid rise during UPDATE is ignored, and that frame is dropped (valids stay 0 until the next rise).
- Binarization: bin = (pix > threshold). Strictly greater; a pixel equal to threshold gives 0.
  - The threshold is constant within a frame, because it only changes in UPDATE.
- Latency: L=1 clock without the filter, L=2 with it.
  - All three valids and data are delayed by exactly L clocks; data is qualified by the delayed valids.
  - When valids are gated, video_data_out is 0x00.
- Gaps in video_data_valid are preserved cycle-for-cycle.
- Reset mid-frame: the partial statistics are discarded and the output goes quiet at once. The threshold returns to DEFAULT_THR, and the FSM re-enters WAIT_IDLE.

Optional Feature:
Macro MAZE_BINARIZER_MAJORITY_EN.
- When defined: a causal 3-tap horizontal majority filter follows binarization.
  - out[i] = maj(b[i], b[i-1], b[i-2]).
  - The history shifts only on video_data_valid and reloads at line start.
  - A missing predecessor (i<2 in the line) is replaced by b[i]. So pixel 0 equals b0, and pixel 1 equals b1.
  - L=2.
- When undefined: out = bin directly; L=1; no history registers.

Decomposition:
- Package maze_video_pkg holds:
  - FSM state enum (WAIT_IDLE, WAIT_FRAME, IN_FRAME, UPDATE);
  - pixel width 8 and the constants PIX_WHITE=8'hFF, PIX_BLACK=8'h00;
  - a video-sync struct {frame_valid, line_valid, data_valid}, reused by the downstream stage.
- One natural sub-module: frame_minmax_stats. It holds the running min/max, the seen-pixel flag, and the clamp/midpoint logic, and exports threshold_next and contrast_ok. The sync delay line and FSM stay in the top.

Test Plan:
- Reset held 5 cycles, then release mid-frame -> no *_valid_out until the next frame_valid rise; threshold==150.
- Frame of pixels in [20,200] -> stats_valid pulse 1 cycle after the frame_valid fall; threshold=110. In the next frame, pixel 110 gives 0x00 and 111 gives 0xFF.
- Frame with pixels in [100,120] -> low_contrast=1; threshold unchanged at 110.
- Frame in [0,10] with MIN_CONTRAST=0 -> midpoint 5 clamped to threshold=40. Frame in [240,255] -> threshold=220.
- Input with random data_valid gaps -> the output valids equal the input valids delayed by exactly L clocks, bit-exact.
- MAJORITY_EN with line pattern 0,0,255,0,0,255,255,0 at threshold 150 -> output 00,00,00,00,00,00,FF,FF.
